// File: rtl/icache_ctrl.sv
// Sequencing controller for a direct-mapped instruction cache.
// It drives the valid-bit array, tag SRAM and data SRAM, refills lines on a miss and runs a full invalidate sweep.
module icache_ctrl #(
    parameter int S_INDEX = 4,
    parameter int TAG_W   = 23
) (
    input  logic                 clk0,
    input  logic                 rst0_n,
    // fetch requester
    input  logic [31:0]          ufp_addr,
    input  logic                 ufp_read,
    output logic [31:0]          ufp_rdata,
    output logic                 ufp_resp,
    // invalidate-all
    input  logic                 flush,
    output logic                 flush_done,
    // refill memory port
    output logic [31:0]          dfp_addr,
    output logic                 dfp_read,
    input  logic [255:0]         dfp_rdata,
    input  logic                 dfp_resp,
    // valid-bit array
    output logic                 va_csb,
    output logic                 va_web,
    output logic [S_INDEX-1:0]   va_addr0,
    output logic [S_INDEX-1:0]   va_addr1,
    output logic                 va_din,
    input  logic                 va_dout,
    // tag SRAM
    output logic                 ts_csb,
    output logic                 ts_web,
    output logic [S_INDEX-1:0]   ts_addr,
    output logic [TAG_W-1:0]     ts_din,
    input  logic [TAG_W-1:0]     ts_dout,
    // data SRAM
    output logic                 ds_csb,
    output logic                 ds_web,
    output logic [S_INDEX-1:0]   ds_addr,
    output logic [255:0]         ds_din,
    input  logic [255:0]         ds_dout
);

    localparam int NUM_SETS = 2 ** S_INDEX;
    localparam int CNT_W    = S_INDEX + 1;
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(NUM_SETS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL,
        FILL_WAIT,
        FLUSH
    } state_t;

    state_t              state_q, state_d;
    logic [31:2]         addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                flush_pend_q, flush_pend_d;
    logic                hit_resp_q, hit_resp_d;
    logic [31:0]         hit_rdata_q, hit_rdata_d;

    logic [TAG_W-1:0]    req_tag;
    logic [S_INDEX-1:0]  req_idx;
    logic [S_INDEX-1:0]  in_idx;
    logic [7:0]          word_bit;
    logic                hit;
    logic                addr_lsb_unused;

    assign req_tag         = addr_q[31:32-TAG_W];
    assign req_idx         = addr_q[S_INDEX+4:5];
    assign in_idx          = ufp_addr[S_INDEX+4:5];
    assign word_bit        = {addr_q[4:2], 5'd0};
    assign hit             = va_dout && (ts_dout == req_tag);
    assign addr_lsb_unused = ^ufp_addr[1:0];

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            hit_resp_q   <= 1'b0;
            hit_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            hit_resp_q   <= hit_resp_d;
            hit_rdata_q  <= hit_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        hit_resp_d   = 1'b0;
        hit_rdata_d  = '0;

        ufp_resp     = hit_resp_q;
        ufp_rdata    = hit_rdata_q;
        flush_done   = 1'b0;
        dfp_addr     = '0;
        dfp_read     = 1'b0;
        va_csb       = 1'b1;
        va_web       = 1'b1;
        va_addr0     = '0;
        va_addr1     = '0;
        va_din       = 1'b0;
        ts_csb       = 1'b1;
        ts_web       = 1'b1;
        ts_addr      = '0;
        ts_din       = '0;
        ds_csb       = 1'b1;
        ds_web       = 1'b1;
        ds_addr      = '0;
        ds_din       = '0;

        case (state_q)
            IDLE: begin
                if (flush || flush_pend_q) begin
                    state_d      = FLUSH;
                    cnt_d        = '0;
                    flush_pend_d = 1'b0;
                // the requester still holds ufp_read while the registered hit response is out
                end else if (ufp_read && !hit_resp_q) begin
                    addr_d   = ufp_addr[31:2];
                    va_csb   = 1'b0;
                    va_addr1 = in_idx;
                    ts_csb   = 1'b0;
                    ts_addr  = in_idx;
                    ds_csb   = 1'b0;
                    ds_addr  = in_idx;
                    state_d  = LOOKUP;
                end
            end
            LOOKUP: begin
                if (flush) flush_pend_d = 1'b1;
                if (hit) begin
                    hit_resp_d  = 1'b1;
                    hit_rdata_d = ds_dout[word_bit +: 32];
                    state_d     = IDLE;
                end else begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (flush) flush_pend_d = 1'b1;
                dfp_addr = {addr_q[31:5], 5'd0};
                dfp_read = 1'b1;
                if (dfp_resp) begin
                    ts_csb    = 1'b0;
                    ts_web    = 1'b0;
                    ts_addr   = req_idx;
                    ts_din    = req_tag;
                    ds_csb    = 1'b0;
                    ds_web    = 1'b0;
                    ds_addr   = req_idx;
                    ds_din    = dfp_rdata;
                    va_csb    = 1'b0;
                    va_web    = 1'b0;
                    va_addr0  = req_idx;
                    va_din    = 1'b1;
                    ufp_resp  = 1'b1;
                    ufp_rdata = dfp_rdata[word_bit +: 32];
                    state_d   = FILL_WAIT;
                end
            end
            FILL_WAIT: begin
                if (flush) flush_pend_d = 1'b1;
                state_d = IDLE;
            end
            FLUSH: begin
                if (cnt_q != CNT_END) begin
                    va_csb   = 1'b0;
                    va_web   = 1'b0;
                    va_addr0 = cnt_q[S_INDEX-1:0];
                    va_din   = 1'b0;
                    cnt_d    = cnt_q + CNT_ONE;
                end else begin
                    // drain cycle lets the last delayed valid write land
                    flush_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: behavioural array/memory models, a cache-content model and a per-cycle compare process.
module tb_icache_ctrl;

    localparam int S_INDEX  = 4;
    localparam int TAG_W    = 23;
    localparam int NUM_SETS = 16;
    localparam logic [31:0] K = 32'hDEADAECB;

    logic               clk0 = 1'b0;
    logic               rst0_n = 1'b0;
    logic [31:0]        ufp_addr = '0;
    logic               ufp_read = 1'b0;
    logic [31:0]        ufp_rdata;
    logic               ufp_resp;
    logic               flush = 1'b0;
    logic               flush_done;
    logic [31:0]        dfp_addr;
    logic               dfp_read;
    logic [255:0]       dfp_rdata = '0;
    logic               dfp_resp = 1'b0;
    logic               va_csb, va_web, va_din;
    logic [S_INDEX-1:0] va_addr0, va_addr1;
    logic               va_dout = 1'b0;
    logic               ts_csb, ts_web;
    logic [S_INDEX-1:0] ts_addr;
    logic [TAG_W-1:0]   ts_din;
    logic [TAG_W-1:0]   ts_dout = '0;
    logic               ds_csb, ds_web;
    logic [S_INDEX-1:0] ds_addr;
    logic [255:0]       ds_din;
    logic [255:0]       ds_dout = '0;

    icache_ctrl #(.S_INDEX(S_INDEX), .TAG_W(TAG_W)) dut (
        .clk0(clk0), .rst0_n(rst0_n),
        .ufp_addr(ufp_addr), .ufp_read(ufp_read), .ufp_rdata(ufp_rdata), .ufp_resp(ufp_resp),
        .flush(flush), .flush_done(flush_done),
        .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
        .va_csb(va_csb), .va_web(va_web), .va_addr0(va_addr0), .va_addr1(va_addr1),
        .va_din(va_din), .va_dout(va_dout),
        .ts_csb(ts_csb), .ts_web(ts_web), .ts_addr(ts_addr), .ts_din(ts_din), .ts_dout(ts_dout),
        .ds_csb(ds_csb), .ds_web(ds_web), .ds_addr(ds_addr), .ds_din(ds_din), .ds_dout(ds_dout)
    );

    always #5 clk0 = ~clk0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // memory content: every word holds its own address xor a constant
    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = ({a[31:5], 5'd0} + 32'(4*i)) ^ K;
        return l;
    endfunction

    // array models; valid writes land one edge after being registered
    logic               va_mem [NUM_SETS] = '{default: 1'b1};
    logic [TAG_W-1:0]   ts_mem [NUM_SETS] = '{default: '0};
    logic [255:0]       ds_mem [NUM_SETS] = '{default: '0};
    logic               va_pend_v = 1'b0;
    logic [S_INDEX-1:0] va_pend_a = '0;
    logic               va_pend_d = 1'b0;

    always @(posedge clk0) begin
        if (va_pend_v) va_mem[va_pend_a] <= va_pend_d;
        va_pend_v <= 1'b0;
        if (!va_csb) begin
            if (!va_web) begin
                va_pend_v <= 1'b1;
                va_pend_a <= va_addr0;
                va_pend_d <= va_din;
            end else begin
                va_dout <= va_mem[va_addr1];
            end
        end
        if (!ts_csb) begin
            if (!ts_web) ts_mem[ts_addr] <= ts_din;
            else ts_dout <= ts_mem[ts_addr];
        end
        if (!ds_csb) begin
            if (!ds_web) ds_mem[ds_addr] <= ds_din;
            else ds_dout <= ds_mem[ds_addr];
        end
    end

    // cache-content model, updated per completed transaction
    bit               m_valid [NUM_SETS];
    logic [TAG_W-1:0] m_tag   [NUM_SETS];

    logic [31:0] cur_addr = '0;
    logic [31:0] exp_word = '0;
    bit          req_active = 1'b0;
    bit          exp_miss = 1'b0;
    logic [31:0] last_rdata = '0;
    logic [31:0] last_dfp_addr = '0;

    always @(negedge clk0) begin
        if (!rst0_n) begin
            check("rst_ctrl", {ufp_resp, flush_done, dfp_read, va_csb, va_web, ts_csb, ts_web, ds_csb, ds_web},
                  9'b000_111111);
            check("rst_vals", {ufp_rdata, dfp_addr, va_din, va_addr0, va_addr1, ts_addr, ts_din, ds_addr}, '0);
            check("rst_ds_din", ds_din, '0);
        end else begin
            if (ufp_resp) begin
                check("resp_expected", req_active, 1);
                check("rdata", ufp_rdata, exp_word);
            end
            if (dfp_read) begin
                check("dfp_read_allowed", exp_miss, 1);
                check("dfp_addr", dfp_addr, {cur_addr[31:5], 5'd0});
            end
            if (!ts_csb && !ts_web)
                check("ts_write", {dfp_resp, ts_din, ts_addr}, {1'b1, cur_addr[31:9], cur_addr[8:5]});
            if (!ds_csb && !ds_web) begin
                check("ds_write_cycle", {dfp_resp, ds_addr}, {1'b1, cur_addr[8:5]});
                check("ds_write_data", ds_din, line_of(cur_addr));
            end
            if (!va_csb && !va_web)
                check("va_write_din", va_din, dfp_read);
        end
    end

    task automatic fetch(input logic [31:0] a, input bit pre_flush, input bit flush_mid);
        int  base;
        int  dfp_first;
        int  resp_cyc;
        int  done_cyc;
        bit  hit;
        base      = pre_flush ? 18 : 0;
        dfp_first = -1;
        resp_cyc  = -1;
        done_cyc  = -1;
        if (pre_flush) for (int i = 0; i < NUM_SETS; i++) m_valid[i] = 1'b0;
        hit      = m_valid[a[8:5]] && (m_tag[a[8:5]] == a[31:9]);
        cur_addr = a;
        exp_word = a ^ K;
        exp_miss = !hit;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(posedge clk0); #1;
            dfp_resp = 1'b0;
            flush    = 1'b0;
            if (cyc == 0) begin
                ufp_addr   = a;
                ufp_read   = 1'b1;
                req_active = 1'b1;
                if (pre_flush) flush = 1'b1;
            end
            if (pre_flush && cyc == 5) flush = 1'b1;
            if (dfp_first >= 0 && cyc == dfp_first + 3) begin
                dfp_resp  = 1'b1;
                dfp_rdata = line_of(a);
            end
            if (flush_mid && dfp_first >= 0 && cyc == dfp_first + 1) flush = 1'b1;
            @(negedge clk0);
            if (dfp_read && dfp_first < 0) begin
                dfp_first     = cyc;
                last_dfp_addr = dfp_addr;
            end
            if (flush_done && done_cyc < 0) done_cyc = cyc;
            if (ufp_resp) begin
                resp_cyc   = cyc;
                last_rdata = ufp_rdata;
                break;
            end
        end
        @(posedge clk0); #1;
        ufp_read   = 1'b0;
        req_active = 1'b0;
        dfp_resp   = 1'b0;
        flush      = 1'b0;
        dfp_rdata  = '0;
        check("resp_seen", resp_cyc >= 0, 1);
        if (pre_flush) check("flush_before_fetch_done", done_cyc, 17);
        if (hit) begin
            check("hit_latency", resp_cyc, base + 2);
            check("hit_no_dfp", dfp_first < 0, 1);
        end else begin
            check("miss_dfp_start", dfp_first, base + 2);
            check("miss_resp_in_dfp_resp", resp_cyc, base + 5);
            m_valid[a[8:5]] = 1'b1;
            m_tag[a[8:5]]   = a[31:9];
        end
        exp_miss = 1'b0;
    endtask

    task automatic wait_done(input int exp_n);
        int n;
        n = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk0);
            if (flush_done) begin
                n = i;
                break;
            end
            @(posedge clk0); #1;
            flush = 1'b0;
        end
        check("flush_done_cycle", n, exp_n);
        @(posedge clk0); #1;
        @(negedge clk0);
        check("flush_done_pulse", flush_done, 0);
        for (int i = 0; i < NUM_SETS; i++) m_valid[i] = 1'b0;
    endtask

    task automatic check_array_clear();
        logic [NUM_SETS-1:0] v;
        for (int i = 0; i < NUM_SETS; i++) v[i] = va_mem[i];
        check("flush_cleared", v, '0);
    endtask

    initial begin
        for (int i = 0; i < NUM_SETS; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
        end
        repeat (3) @(posedge clk0);
        #1 rst0_n = 1'b1;

        // flush from idle: done 17 cycles after the request
        @(posedge clk0); #1;
        flush = 1'b1;
        wait_done(17);
        check_array_clear();

        fetch(32'h0000_1024, 1'b0, 1'b0);
        check("pin_dfp_addr", last_dfp_addr, 32'h0000_1020);
        check("pin_rdata_1024", last_rdata, 32'hDEADBEEF);
        fetch(32'h0000_1024, 1'b0, 1'b0);
        check("pin_hit_1024", last_rdata, 32'hDEADBEEF);
        fetch(32'h0000_1038, 1'b0, 1'b0);
        fetch(32'h0000_2024, 1'b0, 1'b0);
        check("pin_rdata_2024", last_rdata, 32'hDEAD8EEF);
        fetch(32'h0000_1024, 1'b0, 1'b0);

        // flush during refill runs after the fetch completes
        fetch(32'h0000_2024, 1'b0, 1'b1);
        wait_done(18);
        check_array_clear();
        fetch(32'h0000_2024, 1'b0, 1'b0);

        fetch(32'h0000_0000, 1'b0, 1'b0);
        fetch(32'hFFFF_FFFC, 1'b0, 1'b0);
        fetch(32'h0000_0000, 1'b0, 1'b0);
        fetch(32'hFFFF_FFFC, 1'b0, 1'b0);
        check("pin_rdata_last", last_rdata, 32'h2152_5137);

        // flush and fetch together: sweep first, fetch pending, extra flush pulse ignored
        fetch(32'h0000_1024, 1'b1, 1'b0);
        fetch(32'h0000_1024, 1'b0, 1'b0);

        // reset mid-refill, then a stale dfp_resp in idle
        cur_addr = 32'h0000_3044;
        exp_word = 32'h0000_3044 ^ K;
        exp_miss = 1'b1;
        @(posedge clk0); #1;
        ufp_addr   = 32'h0000_3044;
        ufp_read   = 1'b1;
        req_active = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk0);
                if (dfp_read) begin
                    seen = 1'b1;
                    break;
                end
                @(posedge clk0); #1;
            end
            check("rst_test_refill_started", seen, 1);
        end
        @(posedge clk0); #1;
        rst0_n     = 1'b0;
        ufp_read   = 1'b0;
        req_active = 1'b0;
        exp_miss   = 1'b0;
        repeat (2) @(posedge clk0);
        #1 rst0_n = 1'b1;
        @(posedge clk0); #1;
        dfp_resp  = 1'b1;
        dfp_rdata = line_of(32'h0000_3044);
        @(negedge clk0);
        check("late_resp_ignored", {ufp_resp, va_csb, ts_csb, ds_csb, dfp_read}, 5'b01110);
        @(posedge clk0); #1;
        dfp_resp  = 1'b0;
        dfp_rdata = '0;
        @(negedge clk0);
        check("late_resp_no_write", {va_pend_v, ufp_resp}, 2'b00);
        fetch(32'h0000_3044, 1'b0, 1'b0);
        fetch(32'h0000_3044, 1'b0, 1'b0);

        repeat (3) @(posedge clk0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
